led_share_scheduler: RTL and testbench



---
 rtl/led_share_scheduler.sv | 149 ++++++++++++++
 tb/tb_led_share_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_share_scheduler.sv
// Two-requester time-slot scheduler for the shared LED1/LED2 pair: prescaler tick, slot-based grant, pattern decode.
// Build with LED_SHARE_FIXED_PRIO_EN defined for fixed priority (requester 0 first); default is round-robin.
module led_share_scheduler #(
  parameter int N    = 12000000,
  parameter int SLOT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic [1:0] MODE0,
  input  logic [1:0] MODE1,
  output logic [1:0] GNT,
  output logic       BUSY,
  output logic       TICK,
  output logic       LED1,
  output logic       LED2
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(N - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);

  typedef enum logic {IDLE, OWN} state_t;

  logic [PW-1:0] ps_q;
  logic          tick_q;
  state_t        state_q, state_n;
  logic [1:0]    gnt_q, gnt_n;
  logic [1:0]    mode_q, mode_n;
  logic          phase_q, phase_n;
  logic [SW-1:0] slot_q, slot_n;
  logic          owner, other, win, do_grant, take_other;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ps_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (ps_q == PS_LAST);
      ps_q   <= (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
    end
  end

  assign owner = gnt_q[1];
  assign other = ~owner;

`ifdef LED_SHARE_FIXED_PRIO_EN
  assign win        = ~REQ[0];
  assign take_other = owner & REQ[0];
`else
  logic ptr_q, ptr_n;

  // On a tie the requester that did not have the LEDs last time wins.
  assign win        = (REQ == 2'b11) ? ~ptr_q : REQ[1];
  assign take_other = REQ[other];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_q <= 1'b1;
    else     ptr_q <= ptr_n;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      mode_q  <= 2'b00;
      phase_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      mode_q  <= mode_n;
      phase_q <= phase_n;
      slot_q  <= slot_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    gnt_n    = gnt_q;
    mode_n   = mode_q;
    phase_n  = phase_q;
    slot_n   = slot_q;
    do_grant = 1'b0;
`ifndef LED_SHARE_FIXED_PRIO_EN
    ptr_n    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        do_grant = |REQ;
      end
      OWN: begin
        // Release beats a coincident tick.
        if (!REQ[owner]) begin
          state_n = IDLE;
          gnt_n   = 2'b00;
        end else if (tick_q) begin
          if (slot_q == SLOT_LAST) begin
            if (take_other) begin
              do_grant = 1'b1;
            end else begin
              slot_n  = '0;
              phase_n = ~phase_q;
            end
          end else begin
            slot_n  = slot_q + SW'(1);
            phase_n = ~phase_q;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 2'b00;
      end
    endcase

    if (do_grant) begin
      // In OWN a grant is always a hand-over to the other requester.
      state_n = OWN;
      gnt_n   = (state_q == OWN) ? {other, owner} : {win, ~win};
      mode_n  = gnt_n[1] ? MODE1 : MODE0;
      phase_n = 1'b0;
      slot_n  = '0;
`ifndef LED_SHARE_FIXED_PRIO_EN
      ptr_n   = gnt_n[1];
`endif
    end
  end

  always_comb begin
    LED1 = 1'b0;
    LED2 = 1'b1;
    if (state_q == OWN) begin
      case (mode_q)
        2'b00:   begin LED1 = 1'b0;    LED2 = 1'b0;     end
        2'b01:   begin LED1 = phase_q; LED2 = ~phase_q; end
        2'b10:   begin LED1 = phase_q; LED2 = phase_q;  end
        default: begin LED1 = 1'b1;    LED2 = 1'b1;     end
      endcase
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = |gnt_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_share_scheduler.sv
// Directed bench for led_share_scheduler with N=3, SLOT=2; tables are edge-by-edge from reset release.
module tb_led_share_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] REQ, MODE0, MODE1, GNT;
  logic       BUSY, TICK, LED1, LED2;
  int         total = 0;
  int         bad   = 0;

  led_share_scheduler #(.N(3), .SLOT(2)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .MODE0(MODE0), .MODE1(MODE1),
    .GNT(GNT), .BUSY(BUSY), .TICK(TICK), .LED1(LED1), .LED2(LED2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] gnt;
    logic       tick;
    logic       l1;
    logic       l2;
  } vec_t;

  vec_t sg[10];
`ifdef LED_SHARE_FIXED_PRIO_EN
  vec_t tie[16];
`else
  vec_t tie[18];
`endif

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] g, input logic t,
                           input logic l1, input logic l2);
    chk({tag, "_gnt"},  GNT,           g);
    chk({tag, "_busy"}, {1'b0, BUSY},  {1'b0, |g});
    chk({tag, "_tick"}, {1'b0, TICK},  {1'b0, t});
    chk({tag, "_led1"}, {1'b0, LED1},  {1'b0, l1});
    chk({tag, "_led2"}, {1'b0, LED2},  {1'b0, l2});
  endtask

  task automatic apply(input vec_t v, input string tag);
    REQ   = v.req;
    MODE0 = v.m0;
    MODE1 = v.m1;
    @(posedge CLK);
    #1;
    check_out(tag, v.gnt, v.tick, v.l1, v.l2);
  endtask

  task automatic do_reset(input string tag);
    RST   = 1'b1;
    REQ   = 2'b00;
    MODE0 = 2'b00;
    MODE1 = 2'b00;
    @(posedge CLK);
    #2;
    check_out(tag, 2'b00, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    // Single requester, blink mode: phase toggles each tick and keeps going across slot ends.
    sg[0] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    sg[1] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    sg[2] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1};
    sg[3] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
    sg[4] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
    sg[5] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
    sg[6] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    sg[7] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    sg[8] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1};
    sg[9] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};

`ifdef LED_SHARE_FIXED_PRIO_EN
    // Both requesting: requester 0 keeps the LEDs; after release, requester 1 gets them.
    for (int i = 0; i < 13; i++) tie[i] = sg[i % 6];
    for (int i = 0; i < 13; i++) begin
      tie[i].req = 2'b11;
      tie[i].m1  = 2'b10;
    end
    tie[13] = '{2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
    tie[14] = '{2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0};
    tie[15] = '{2'b10, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1};
`else
    // Tie, slot hand-over both ways, mode changes mid-grant, early release, re-grant, idle.
    tie[0]  = '{2'b11, 2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1};
    tie[1]  = '{2'b11, 2'b11, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1};
    tie[2]  = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1};
    tie[3]  = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1};
    tie[4]  = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1};
    tie[5]  = '{2'b11, 2'b01, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1};
    tie[6]  = '{2'b11, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    tie[7]  = '{2'b11, 2'b01, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0};
    tie[8]  = '{2'b11, 2'b01, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0};
    tie[9]  = '{2'b11, 2'b01, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1};
    tie[10] = '{2'b11, 2'b01, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1};
    tie[11] = '{2'b11, 2'b01, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1};
    tie[12] = '{2'b11, 2'b01, 2'b11, 2'b01, 1'b0, 1'b0, 1'b1};
    tie[13] = '{2'b10, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
    tie[14] = '{2'b10, 2'b01, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1};
    tie[15] = '{2'b10, 2'b01, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1};
    tie[16] = '{2'b00, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
    tie[17] = '{2'b00, 2'b01, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1};
`endif

    do_reset("rst0");
    foreach (sg[i]) apply(sg[i], $sformatf("sg%0d", i));

    // Mid-grant reset between edges: outputs must drop before the next edge.
    #3;
    RST = 1'b1;
    #1;
    check_out("async_rst", 2'b00, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    REQ = 2'b00;
    // Prescaler restarts from 0: first TICK after the third edge.
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = '{2'b00, 2'b00, 2'b00, 2'b00, (i == 2), 1'b0, 1'b1};
      apply(v, $sformatf("post_rst%0d", i));
    end

    do_reset("rst1");
    foreach (tie[i]) apply(tie[i], $sformatf("tie%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
